// File: rtl/mult_seq_param.sv
// mult_seq_param: sequential WIDTH x WIDTH multiplier reusing one CHUNK x CHUNK multiplier
module mult_seq_param #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("mult_seq_param: WIDTH must be an exact multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               neg_q, neg_d;
    logic [IW-1:0]      i_q, i_d, j_q, j_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [CHUNK-1:0]   a_c, b_c;
    logic [2*CHUNK-1:0] pp;
    logic [2*WIDTH-1:0] pp_ext;
    logic               accept, last_pair;

    // partial product of the current chunk pair, shifted to its weight
    always_comb begin
        a_c = CHUNK'(a_q >> (CHUNK * 32'(i_q)));
        b_c = CHUNK'(b_q >> (CHUNK * 32'(j_q)));
        pp = {{CHUNK{1'b0}}, a_c} * {{CHUNK{1'b0}}, b_c};
        pp_ext = (2*WIDTH)'(pp) << (CHUNK * (32'(i_q) + 32'(j_q)));
    end

    // sequencing, operand latch, chunk walk and product accumulate/negate
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        neg_d = neg_q;
        i_d = i_q;
        j_d = j_q;
        product_d = product_q;
        accept = start && (state_q == IDLE || state_q == DONE);
        last_pair = i_q == LAST && j_q == LAST;
        busy = state_q == CALC || state_q == SIGN;
        done = state_q == DONE;
        if (accept) begin
            state_d = CALC;
            a_d = is_signed && a[WIDTH-1] ? -a : a;
            b_d = is_signed && b[WIDTH-1] ? -b : b;
            neg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            product_d = '0;
            i_d = '0;
            j_d = '0;
        end else if (state_q == CALC) begin
            product_d = product_q + pp_ext;
            j_d = j_q == LAST ? '0 : j_q + 1'b1;
            i_d = last_pair ? '0 : (j_q == LAST ? i_q + 1'b1 : i_q);
            state_d = last_pair ? SIGN : CALC;
        end else if (state_q == SIGN) begin
            product_d = neg_q ? -product_q : product_q;
            state_d = DONE;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            neg_q <= 1'b0;
            i_q <= '0;
            j_q <= '0;
            product_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            neg_q <= neg_d;
            i_q <= i_d;
            j_q <= j_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
endmodule

// File: tb/tb_mult_seq_param.sv
// tb_mult_seq_param: directed and random checks of the sequential multiplier at 32/16 and 24/8
module tb_mult_seq_param;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        st32 = 1'b0, sg32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] p32;
    logic        st24 = 1'b0, sg24 = 1'b0;
    logic [23:0] a24 = '0, b24 = '0;
    logic        busy24, done24;
    logic [47:0] p24;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_seq_param u32 (
        .clk(clk), .reset(reset), .start(st32), .is_signed(sg32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .product(p32)
    );

    mult_seq_param #(.WIDTH(24), .CHUNK(8)) u24 (
        .clk(clk), .reset(reset), .start(st24), .is_signed(sg24), .a(a24), .b(b24),
        .busy(busy24), .done(done24), .product(p24)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref32(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [63:0] ref24(input logic s, input logic [23:0] x, input logic [23:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0] r;
        if (s) begin
            sx = {{40{x[23]}}, x};
            sy = {{40{y[23]}}, y};
            r = sx * sy;
        end else begin
            r = {40'b0, x} * {40'b0, y};
        end
        return {16'b0, r[47:0]};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic launch32(input logic s, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        st32 = 1'b1; sg32 = s; a32 = x; b32 = y;
        @(negedge clk);
        st32 = 1'b0; sg32 = ~s; a32 = $urandom; b32 = $urandom;
    endtask

    task automatic finish32(input logic [63:0] exp, input string tag, input logic lat);
        int cyc = 1;
        int nb;
        check({tag, "_clr"}, p32, 64'd0);
        nb = int'(busy32);
        while (!done32 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            nb += int'(busy32);
        end
        check({tag, "_done"}, 64'(done32), 64'd1);
        check({tag, "_prod"}, p32, exp);
        if (lat) begin
            check({tag, "_lat"}, 64'(cyc), 64'd6);
            check({tag, "_busy"}, 64'(nb), 64'd5);
            @(negedge clk);
            check({tag, "_pulse"}, 64'(done32), 64'd0);
            check({tag, "_hold"}, p32, exp);
        end
    endtask

    task automatic run32(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input string tag);
        launch32(s, x, y);
        finish32(exp, tag, 1'b1);
    endtask

    task automatic run24(input logic s, input logic [23:0] x, input logic [23:0] y,
                         input logic [63:0] exp, input string tag, input logic lat);
        int cyc = 1;
        int nb;
        @(negedge clk);
        st24 = 1'b1; sg24 = s; a24 = x; b24 = y;
        @(negedge clk);
        st24 = 1'b0; sg24 = ~s; a24 = 24'($urandom); b24 = 24'($urandom);
        nb = int'(busy24);
        while (!done24 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            nb += int'(busy24);
        end
        check({tag, "_done"}, 64'(done24), 64'd1);
        check({tag, "_prod"}, {16'b0, p24}, exp);
        if (lat) begin
            check({tag, "_lat"}, 64'(cyc), 64'd11);
            check({tag, "_busy"}, 64'(nb), 64'd10);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        logic s;
        logic [31:0] x, y;
        logic [23:0] x24, y24;
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_prod", p32, 64'd0);
        check("rst_prod24", {16'b0, p24}, 64'd0);
        reset = 1'b0;

        run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "umax");
        run32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, "neg1sq");
        run32(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, "min_x1");
        run32(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min_sq");
        run32(1'b1, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, "7xm3");
        run32(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "u_min_sq");
        run32(1'b0, 32'd0, 32'hDEAD_BEEF, 64'h0, "zero");

        launch32(1'b0, 32'd1000, 32'd3000);
        nd = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            st32 = 1'b1; sg32 = 1'b1; a32 = $urandom; b32 = $urandom;
        end
        @(negedge clk);
        st32 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done32) begin
                nd++;
                check("busy_start_prod", p32, 64'd3_000_000);
            end
        end
        check("busy_start_pulses", 64'(nd), 64'd1);

        launch32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy32), 64'd0);
        check("arst_done", 64'(done32), 64'd0);
        check("arst_prod", p32, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            nd += int'(done32);
        end
        check("arst_no_done", 64'(nd), 64'd0);
        run32(1'b0, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000, "post_rst");

        launch32(1'b0, 32'h1234, 32'h10);
        finish32(64'h12340, "b2b_first", 1'b0);
        st32 = 1'b1; sg32 = 1'b0; a32 = 32'd3; b32 = 32'd5;
        @(negedge clk);
        st32 = 1'b0; a32 = $urandom; b32 = $urandom;
        finish32(64'hF, "b2b", 1'b1);

        run24(1'b0, 24'hABCDEF, 24'h123456, 64'h0C37_9A59_BA4A, "w24", 1'b1);
        run24(1'b1, 24'h800000, 24'h800000, 64'h4000_0000_0000, "w24_min_sq", 1'b1);
        run24(1'b1, 24'd7, 24'hFFFFFD, 64'hFFFF_FFFF_FFEB, "w24_7xm3", 1'b0);

        for (int k = 0; k < 1000; k++) begin
            s = 1'($urandom_range(0, 1));
            x = pick32();
            y = pick32();
            launch32(s, x, y);
            finish32(ref32(s, x, y), "rnd32", 1'b0);
        end
        for (int k = 0; k < 200; k++) begin
            s = 1'($urandom_range(0, 1));
            x24 = 24'(pick32());
            y24 = 24'(pick32());
            run24(s, x24, y24, ref24(s, x24, y24), "rnd24", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
